// File: rtl/matrix_pkg.sv
// matrix_pkg
// Shared types and constants for the matrix result path.
//   result_t      : signed result value, twice the operand width
//   drain_entry_t : one buffered result {data, addr, last}
//   drain_state_t : input-side frame tracker states
//   FRAME_LEN     : number of results in one frame (N*N)
// The DEF_* constants give the default build widths. Modules that take
// N and W as parameters size their own copies of these types.
package matrix_pkg;

   localparam int DEF_N = 2;
   localparam int DEF_W = 8;
   localparam int FRAME_LEN = DEF_N * DEF_N;

   typedef logic signed [2*DEF_W-1:0] result_t;

   typedef struct packed {
      result_t     data;
      logic [31:0] addr;
      logic        last;
   } drain_entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with registered storage and a combinational head.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   push, wdata     : write request and data (ignored when full with no pop)
//   pop             : read request (ignored when empty)
//   rdata           : current head entry
//   full, empty     : occupancy status
//   count           : occupancy 0..DEPTH
// Pointers carry one extra bit so full and empty can be told apart.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_pop;
   logic             do_push;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign count   = wptr - rptr;
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

endmodule

// File: rtl/c_result_drain.sv
// c_result_drain
// Buffers results from the control FSM's C write port and drains them to
// the host over a valid/ready stream, tagging each with its address and an
// end-of-frame marker. Sticky error flags report dropped writes, bad
// addresses and frames cut short by done_all.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   write_en_C, write_addr_C, C_in  : result write port
//   done_all                        : completion indication from control FSM
//   m_valid/m_ready/m_data/m_addr/m_last : output stream
//   frame_done                      : pulse after the last entry of a frame leaves
//   fill_level                      : FIFO occupancy
//   overflow_err, addr_err, short_err : sticky error flags
//   sat_flag                        : sticky clamp indicator (C_DRAIN_SAT_EN only)
// Build option: define C_DRAIN_SAT_EN to clamp results to OUT_W signed bits
// at push time; OUT_W exists only in that build.
module c_result_drain
   import matrix_pkg::*;
#(
   parameter int N     = 2,
   parameter int W     = 8,
   parameter int DEPTH = 4
`ifdef C_DRAIN_SAT_EN
   , parameter int OUT_W = 12
`endif
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     write_en_C,
   input  logic [31:0]              write_addr_C,
   input  logic signed [2*W-1:0]    C_in,
   input  logic                     done_all,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic signed [2*W-1:0]    m_data,
   output logic [31:0]              m_addr,
   output logic                     m_last,
   output logic                     frame_done,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic                     overflow_err,
   output logic                     addr_err,
   output logic                     short_err
`ifdef C_DRAIN_SAT_EN
   , output logic                   sat_flag
`endif
);

   localparam logic [31:0] FRAME_LEN_L = 32'(N * N);

   typedef struct packed {
      logic signed [2*W-1:0] data;
      logic [31:0]           addr;
      logic                  last;
   } entry_t;

   drain_state_t          state;
   drain_state_t          state_next;
   logic [31:0]           frame_cnt;
   logic                  done_prev;
   logic                  done_rise;
   logic                  in_range;
   logic                  pop;
   logic                  push;
   logic                  push_last;
   logic                  short_set;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic signed [2*W-1:0] store_data;
   logic                  sat_hit;
   entry_t                wr_entry;
   entry_t                head;

   assign in_range  = (write_addr_C < FRAME_LEN_L);
   assign pop       = m_valid && m_ready;
   assign push      = write_en_C && in_range && (!fifo_full || pop);
   assign push_last = push && (frame_cnt == FRAME_LEN_L - 1);
   assign done_rise = done_all && !done_prev;

   // Optional clamp to the OUT_W signed range before storing.
   always_comb begin
      store_data = C_in;
      sat_hit    = 1'b0;
`ifdef C_DRAIN_SAT_EN
      if (C_in > $signed((2*W)'((1 << (OUT_W-1)) - 1))) begin
         store_data = $signed((2*W)'((1 << (OUT_W-1)) - 1));
         sat_hit    = 1'b1;
      end else if (C_in < -$signed((2*W)'(1 << (OUT_W-1)))) begin
         store_data = -$signed((2*W)'(1 << (OUT_W-1)));
         sat_hit    = 1'b1;
      end
`endif
   end

   assign wr_entry = '{data: store_data, addr: write_addr_C, last: push_last};

   sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fill_level)
   );

   // Head fields are gated so the stream reads all-zero while empty.
   assign m_valid = !fifo_empty;
   assign m_data  = fifo_empty ? '0 : head.data;
   assign m_addr  = fifo_empty ? '0 : head.addr;
   assign m_last  = fifo_empty ? 1'b0 : head.last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // A push that completes the frame takes precedence over done_all.
   always_comb begin
      state_next = state;
      short_set  = 1'b0;
      case (state)
         IDLE: begin
            if (push && !push_last) state_next = FILL;
         end
         FILL: begin
            if (push_last) begin
               state_next = IDLE;
            end else if (done_rise) begin
               state_next = IDLE;
               short_set  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt    <= '0;
         done_prev    <= 1'b0;
         frame_done   <= 1'b0;
         overflow_err <= 1'b0;
         addr_err     <= 1'b0;
         short_err    <= 1'b0;
      end else begin
         done_prev  <= done_all;
         frame_done <= pop && head.last;
         if (short_set)      frame_cnt <= '0;
         else if (push_last) frame_cnt <= '0;
         else if (push)      frame_cnt <= frame_cnt + 1'b1;
         if (write_en_C && in_range && fifo_full && !pop) overflow_err <= 1'b1;
         if (write_en_C && !in_range)                     addr_err     <= 1'b1;
         if (short_set)                                   short_err    <= 1'b1;
      end
   end

`ifdef C_DRAIN_SAT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                sat_flag <= 1'b0;
      else if (push && sat_hit) sat_flag <= 1'b1;
   end
`else
   logic unused_sat;
   assign unused_sat = sat_hit;
`endif

endmodule
